bscan_user_chain: RTL
=====================

# bscan_user_chain

Parametrised multi-chain user data register engine for the boundary-scan user instruction. Sits between the BSCAN primitive's CAPTURE/SHIFT/UPDATE/SEL/TDI controls and fabric logic. Gives each of NUM_CHAINS chains a DATA_WIDTH capture/shift/update register, a one-cycle update strobe and optional shift-length checking. All logic runs on the JTAG user clock (DRCK), supplied as CLK.

## Interface
- DATA_WIDTH, 32, bits per chain register (>= 2)
- NUM_CHAINS, 4, number of independent user chains (>= 1)
- CLK  input  1  JTAG user clock (DRCK); all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- SEL  input  NUM_CHAINS  chain select; lowest set index wins
- TAP_RESET  input  1  TAP test-logic-reset indication
- CAPTURE  input  1  capture-DR
- SHIFT  input  1  shift-DR
- UPDATE  input  1  update-DR
- TDI  input  1  serial data in
- TDO  output  1  serial data out
- CAP_DATA  input  NUM_CHAINS*DATA_WIDTH  parallel capture values; chain i at [i*DATA_WIDTH +: DATA_WIDTH]
- UPD_DATA  output  NUM_CHAINS*DATA_WIDTH  committed update values, same packing
- UPD_VALID  output  NUM_CHAINS  one-cycle strobe per chain on commit
- LEN_ERR  output  1  sticky shift-length mismatch flag

## Operation
- One shared shift register SR[DATA_WIDTH-1:0], bit counter CNT (saturates at DATA_WIDTH+1, width clog2(DATA_WIDTH+2)), latched chain index ACT and valid bit ACT_V.
- States: IDLE, CAPT, SHFT, UPDT. Inputs sampled at each rising CLK edge; priority RST > TAP_RESET > CAPTURE > SHIFT > UPDATE.
- IDLE: CAPTURE with any SEL bit -> CAPT: ACT = lowest set SEL index, ACT_V=1, SR = CAP_DATA slice ACT, CNT=0. CAPTURE with SEL=0 -> stay IDLE, ACT_V=0.
- CAPT/SHFT: SHIFT=1 -> SHFT: SR = {TDI, SR[DATA_WIDTH-1:1]} (LSB out first), CNT = CNT+1 saturating. UPDATE=1 -> UPDT. CAPTURE=1 -> re-capture as from IDLE.
- UPDT: commit (see Configuration): UPD_DATA slice ACT = SR, UPD_VALID[ACT]=1 for exactly the next cycle. Then IDLE, ACT_V=0. Other slices unchanged.
- SHIFT or UPDATE seen in IDLE: ignored, no state change.
- TAP_RESET: state IDLE, SR=0, CNT=0, ACT_V=0; UPD_DATA and LEN_ERR retained.
- TDO = SR[0] when ACT_V=1, else 0; combinational from registers only.

## Timing
- Reset values: TDO=0, UPD_DATA=0, UPD_VALID=0, LEN_ERR=0, state IDLE, SR=0, CNT=0, ACT_V=0.
- Capture edge -> SR[0] on TDO in the same cycle after that edge (zero extra latency).
- Each SHIFT edge presents the next bit on TDO after that edge.
- UPDATE edge -> UPD_DATA and UPD_VALID change together after that edge. UPD_VALID drops after one cycle.
- Back-to-back scans: a CAPTURE on the cycle after UPDT is accepted normally.
- RST mid-shift: everything returns to reset values on that edge, including UPD_DATA.
- More than DATA_WIDTH shifts: SR keeps rotating TDI in. CNT saturates at DATA_WIDTH+1.

## Configuration
- Macro BSCAN_USER_LEN_CHECK_EN.
- Defined: commit only if CNT == DATA_WIDTH. Otherwise no UPD_DATA change, no UPD_VALID, and LEN_ERR set to 1 until RST. TAP_RESET does not clear LEN_ERR.
- Undefined: every UPDT commits regardless of CNT. LEN_ERR tied to 0; the counter may be removed.

## Test plan
All scenarios use DATA_WIDTH=8, NUM_CHAINS=2.
- Reset: assert RST for 2 cycles -> all outputs 0, TDO=0.
- Chain 1 round trip: CAP_DATA slice1=0xA5, SEL=2'b10, CAPTURE, 8 SHIFTs with TDI bits of 0x3C LSB first, UPDATE -> TDO emits 1,0,1,0,0,1,0,1. UPD_DATA slice1=0x3C, slice0 unchanged. UPD_VALID=2'b10 for one cycle.
- Select priority: SEL=2'b11, CAP_DATA slice0=0x01, CAPTURE -> TDO=1 (chain 0 active). Update commits to slice0 only.
- Short scan with macro defined: 5 SHIFTs then UPDATE -> no UPD_VALID, UPD_DATA unchanged, LEN_ERR=1 and held through TAP_RESET. Without macro: slice updated, LEN_ERR=0.
- TAP_RESET mid-shift after 3 SHIFTs -> state IDLE, TDO=0, UPD_DATA retained. A following UPDATE is ignored.
- No select: SEL=0 with CAPTURE, SHIFT, UPDATE -> TDO=0, no UPD_VALID, no LEN_ERR.

Source files
------------

// File: rtl/bscan_user_chain_if.sv
// Boundary-scan user chain bus: TAP-side controls, serial data and the
// parallel capture/update payloads exchanged with fabric logic.
//   master : drives SEL/TAP_RESET/CAPTURE/SHIFT/UPDATE/TDI/CAP_DATA,
//            observes TDO/UPD_DATA/UPD_VALID/LEN_ERR
//   slave  : the chain engine (opposite directions)
interface bscan_user_chain_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CHAINS = 4
);
  logic [NUM_CHAINS-1:0]            SEL;
  logic                             TAP_RESET;
  logic                             CAPTURE;
  logic                             SHIFT;
  logic                             UPDATE;
  logic                             TDI;
  logic                             TDO;
  logic [NUM_CHAINS*DATA_WIDTH-1:0] CAP_DATA;
  logic [NUM_CHAINS*DATA_WIDTH-1:0] UPD_DATA;
  logic [NUM_CHAINS-1:0]            UPD_VALID;
  logic                             LEN_ERR;

  modport master (
    output SEL, TAP_RESET, CAPTURE, SHIFT, UPDATE, TDI, CAP_DATA,
    input  TDO, UPD_DATA, UPD_VALID, LEN_ERR
  );

  modport slave (
    input  SEL, TAP_RESET, CAPTURE, SHIFT, UPDATE, TDI, CAP_DATA,
    output TDO, UPD_DATA, UPD_VALID, LEN_ERR
  );
endinterface

// File: rtl/bscan_user_chain.sv
// Multi-chain user data register engine for the boundary-scan user
// instruction. One shared shift register serves NUM_CHAINS chains; the
// chain latched at capture receives the shifted value on update, with a
// one-cycle UPD_VALID strobe.
// Ports:
//   CLK  - JTAG user clock (DRCK), rising-edge
//   RST  - synchronous active-high reset
//   bus  - bscan_user_chain_if.slave (controls, TDI/TDO, capture/update data)
// Optional feature: define BSCAN_USER_LEN_CHECK_EN to commit only scans of
// exactly DATA_WIDTH shifts and flag others on the sticky LEN_ERR.
module bscan_user_chain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CHAINS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  bscan_user_chain_if.slave    bus
);

  localparam int unsigned IDX_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

  typedef enum logic [1:0] {IDLE, CAPT, SHFT, UPDT} state_e;

  state_e                           state_q;
  logic [DATA_WIDTH-1:0]            sr_q;
  logic [IDX_W-1:0]                 act_q;
  logic                             act_v_q;
  logic [NUM_CHAINS*DATA_WIDTH-1:0] upd_data_q;
  logic [NUM_CHAINS-1:0]            upd_valid_q;

  logic                             sel_any_c;
  logic [IDX_W-1:0]                 sel_idx_c;
  logic [DATA_WIDTH-1:0]            cap_slice_c;
  logic                             commit_ok_c;

`ifdef BSCAN_USER_LEN_CHECK_EN
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 2);
  logic [CNT_W-1:0] cnt_q;
  logic             len_err_q;
  assign commit_ok_c = (cnt_q == CNT_W'(DATA_WIDTH));
  assign bus.LEN_ERR = len_err_q;
`else
  assign commit_ok_c = 1'b1;
  assign bus.LEN_ERR = 1'b0;
`endif

  // Lowest set select bit wins; walk downwards so the last hit is the lowest.
  always_comb begin
    sel_any_c = |bus.SEL;
    sel_idx_c = '0;
    for (int i = int'(NUM_CHAINS) - 1; i >= 0; i--) begin
      if (bus.SEL[i]) sel_idx_c = IDX_W'(i);
    end
  end

  // Capture value of the chain that would be selected this cycle.
  always_comb begin
    cap_slice_c = '0;
    for (int i = 0; i < int'(NUM_CHAINS); i++) begin
      if (sel_idx_c == IDX_W'(i)) cap_slice_c = bus.CAP_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan state machine; UPD_VALID defaults low so the strobe lasts one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      act_q       <= '0;
      act_v_q     <= 1'b0;
      upd_data_q  <= '0;
      upd_valid_q <= '0;
`ifdef BSCAN_USER_LEN_CHECK_EN
      cnt_q       <= '0;
      len_err_q   <= 1'b0;
`endif
    end else begin
      upd_valid_q <= '0;
      if (bus.TAP_RESET) begin
        // UPD_DATA and LEN_ERR survive a TAP reset.
        state_q <= IDLE;
        sr_q    <= '0;
        act_v_q <= 1'b0;
`ifdef BSCAN_USER_LEN_CHECK_EN
        cnt_q   <= '0;
`endif
      end else if (bus.CAPTURE) begin
        // Capture behaves identically from every state.
        if (sel_any_c) begin
          state_q <= CAPT;
          act_q   <= sel_idx_c;
          act_v_q <= 1'b1;
          sr_q    <= cap_slice_c;
`ifdef BSCAN_USER_LEN_CHECK_EN
          cnt_q   <= '0;
`endif
        end else begin
          state_q <= IDLE;
          act_v_q <= 1'b0;
        end
      end else begin
        case (state_q)
          CAPT, SHFT: begin
            if (bus.SHIFT) begin
              state_q <= SHFT;
              sr_q    <= {bus.TDI, sr_q[DATA_WIDTH-1:1]};
`ifdef BSCAN_USER_LEN_CHECK_EN
              if (cnt_q != CNT_W'(DATA_WIDTH + 1)) cnt_q <= cnt_q + CNT_W'(1);
`endif
            end else if (bus.UPDATE) begin
              state_q <= UPDT;
              if (commit_ok_c) begin
                for (int i = 0; i < int'(NUM_CHAINS); i++) begin
                  if (act_q == IDX_W'(i)) begin
                    upd_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= sr_q;
                    upd_valid_q[i]                         <= 1'b1;
                  end
                end
              end
`ifdef BSCAN_USER_LEN_CHECK_EN
              else begin
                len_err_q <= 1'b1;
              end
`endif
            end
          end
          UPDT: begin
            state_q <= IDLE;
            act_v_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.TDO       = act_v_q & sr_q[0];
  assign bus.UPD_DATA  = upd_data_q;
  assign bus.UPD_VALID = upd_valid_q;

endmodule
